// File: rtl/fetch0.sv
// -----------------------------------------------------------------------------
// fetch0 -- front-end PC generator and instruction-request stage.
//
// Owns the architectural fetch PC, issues in-order word requests to the
// instruction cache, and buffers returned instructions for decode. Redirects
// from the CSR unit and from execute reload the PC, flush the output buffer
// and mark every fetch still in flight as stale so its response is discarded.
//
// Ports
//   clk_core, reset_n         core clock, synchronous active-low reset
//   csr_kill                  flush output buffer and in-flight fetches
//   csr_fe_inhibit            block new request issue
//   csr_setpc / csr_newpc     CSR redirect (word address)
//   ex_setpc / ex_newpc       execute branch/jump redirect (word address)
//   fe0_req_valid/_pc         icache request, handshakes with ic_req_ready
//   ic_resp_valid/_data/_fault  icache response, in request order
//   fe0_valid/_pc/_insn/_exc  instruction offered to decode
//   de_stall                  decode not accepting
// -----------------------------------------------------------------------------
module fetch0 #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_core,
   input  logic        reset_n,
   input  logic        csr_kill,
   input  logic        csr_fe_inhibit,
   input  logic        csr_setpc,
   input  logic [31:2] csr_newpc,
   input  logic        ex_setpc,
   input  logic [31:2] ex_newpc,
   output logic        fe0_req_valid,
   output logic [31:2] fe0_req_pc,
   input  logic        ic_req_ready,
   input  logic        ic_resp_valid,
   input  logic [31:0] ic_resp_data,
   input  logic        ic_resp_fault,
   output logic        fe0_valid,
   output logic [31:2] fe0_pc,
   output logic [31:0] fe0_insn,
   output logic        fe0_exc,
   input  logic        de_stall
);

   localparam logic [31:2] RESET_WPC = RESET_PC[31:2];

   // Architectural fetch PC and counters.
   logic [31:2] pc_q, pc_d;
   logic [1:0]  outstanding_q, outstanding_d;
   logic [1:0]  count_q, count_d;
   logic [1:0]  drop_cnt_q, drop_cnt_d;

   // In-flight PC queue (depth 2).
   logic [31:2] ifq_pc_q [2];
   logic        ifq_wr_q, ifq_wr_d;
   logic        ifq_rd_q, ifq_rd_d;

   // Output FIFO of {pc, insn, fault} (depth 2).
   logic [31:2] ofq_pc_q    [2];
   logic [31:0] ofq_insn_q  [2];
   logic        ofq_fault_q [2];
   logic        ofq_wr_q, ofq_wr_d;
   logic        ofq_rd_q, ofq_rd_d;

   logic redir;
   logic credit;
   logic issue;
   logic drop;
   logic enq;
   logic deq;

   assign redir  = csr_setpc | ex_setpc | csr_kill;
   // Credit covers both fetches in flight and entries already buffered, so a
   // returning response always finds a free FIFO slot.
   assign credit = ({1'b0, outstanding_q} + {1'b0, count_q}) < 3'd2;

   // reset_n gating keeps the request quiet while the block is held in reset.
   assign fe0_req_valid = reset_n & ~redir & ~csr_fe_inhibit & credit;
   assign fe0_req_pc    = pc_q;

   assign issue = fe0_req_valid & ic_req_ready;
   // A response is stale if a redirect is happening now or an earlier one
   // left fetches to discard.
   assign drop  = ic_resp_valid & (redir | (drop_cnt_q != 2'd0));
   assign enq   = ic_resp_valid & ~drop;
   assign deq   = (count_q != 2'd0) & ~de_stall;

   assign fe0_valid = count_q != 2'd0;
   assign fe0_pc    = ofq_pc_q[ofq_rd_q];
   assign fe0_insn  = ofq_insn_q[ofq_rd_q];
   assign fe0_exc   = ofq_fault_q[ofq_rd_q];

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path through
      // the if/else chains can leave one unassigned and infer a latch.
      pc_d          = pc_q;
      outstanding_d = outstanding_q;
      count_d       = count_q;
      drop_cnt_d    = drop_cnt_q;
      ifq_wr_d      = ifq_wr_q;
      ifq_rd_d      = ifq_rd_q;
      ofq_wr_d      = ofq_wr_q;
      ofq_rd_d      = ofq_rd_q;

      // csr_setpc wins; ex_setpc is ignored under csr_kill; kill alone holds pc.
      if (csr_setpc)                  pc_d = csr_newpc;
      else if (ex_setpc && !csr_kill) pc_d = ex_newpc;
      else if (issue)                 pc_d = pc_q + 30'd1;

      if (issue && !ic_resp_valid)      outstanding_d = outstanding_q + 2'd1;
      else if (!issue && ic_resp_valid) outstanding_d = outstanding_q - 2'd1;

      if (issue)         ifq_wr_d = ~ifq_wr_q;
      if (ic_resp_valid) ifq_rd_d = ~ifq_rd_q;

      if (redir) begin
         // Everything still outstanding after this cycle is stale. No issue can
         // happen in a redirect cycle, so that is exactly outstanding_d.
         drop_cnt_d = outstanding_d;
         count_d    = 2'd0;
         ofq_wr_d   = 1'b0;
         ofq_rd_d   = 1'b0;
      end else begin
         if (drop) drop_cnt_d = drop_cnt_q - 2'd1;
         if (enq && !deq)      count_d = count_q + 2'd1;
         else if (!enq && deq) count_d = count_q - 2'd1;
         if (enq) ofq_wr_d = ~ofq_wr_q;
         if (deq) ofq_rd_d = ~ofq_rd_q;
      end
   end

   always_ff @(posedge clk_core) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!reset_n) begin
         pc_q          <= RESET_WPC;
         outstanding_q <= 2'd0;
         count_q       <= 2'd0;
         drop_cnt_q    <= 2'd0;
         ifq_wr_q      <= 1'b0;
         ifq_rd_q      <= 1'b0;
         ofq_wr_q      <= 1'b0;
         ofq_rd_q      <= 1'b0;
         // NOTE: the output FIFO storage is reset because its head drives
         // fe0_pc/fe0_insn/fe0_exc, which must read zero out of reset.
         for (int i = 0; i < 2; i++) begin
            ofq_pc_q[i]    <= '0;
            ofq_insn_q[i]  <= '0;
            ofq_fault_q[i] <= 1'b0;
         end
      end else begin
         pc_q          <= pc_d;
         outstanding_q <= outstanding_d;
         count_q       <= count_d;
         drop_cnt_q    <= drop_cnt_d;
         ifq_wr_q      <= ifq_wr_d;
         ifq_rd_q      <= ifq_rd_d;
         ofq_wr_q      <= ofq_wr_d;
         ofq_rd_q      <= ofq_rd_d;
         if (enq) begin
            ofq_pc_q[ofq_wr_q]    <= ifq_pc_q[ifq_rd_q];
            ofq_insn_q[ofq_wr_q]  <= ic_resp_data;
            ofq_fault_q[ofq_wr_q] <= ic_resp_fault;
         end
      end
   end

   // In-flight PC storage is never read before written, so it carries no reset.
   always_ff @(posedge clk_core) begin
      if (issue) ifq_pc_q[ifq_wr_q] <= pc_q;
   end

   // A response with nothing outstanding means the icache has lost ordering.
   resp_needs_outstanding: assert property (
      @(posedge clk_core) disable iff (!reset_n)
      !(ic_resp_valid && (outstanding_q == 2'd0)));

endmodule
